dealigner: RTL and testbench
============================

DEALIGNER -- requirements
Module: dealigner

Interface
REQ-001 Parameter DATA_IN_WIDTH, default 256: packed input word width in bits (32 bytes).
REQ-002 Parameter TAG_WIDTH, default 16: record tag width.
REQ-003 Parameter LEN_WIDTH, default 8: record length field width, unit = bytes of payload.
REQ-004 Parameter MAX_LEN, default 32: largest legal payload length in bytes.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  256  packed record stream word; byte 0 = in_data[7:0].
REQ-008 in_valid  input  1  in_data holds a word.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 flush  input  1  discard all buffered, partially received bytes.
REQ-011 out_tag  output  16  tag of extracted record.
REQ-012 out_data  output  256  payload; byte i in bits [8i+7:8i]; bytes >= out_len SHALL be zero.
REQ-013 out_len  output  8  payload length in bytes, 0..32.
REQ-014 out_valid  output  1  out_tag/out_data/out_len hold a record.
REQ-015 out_ready  input  1  downstream consumes the record this cycle.
REQ-016 err  output  1  sticky; illegal length header seen.

Function
REQ-017 The block SHALL undo the Aligner packing: the stream is a byte sequence, LSB-first across consecutive words; each record = len byte, then tag (2 bytes, low byte first), then len payload bytes; records are contiguous, with no padding.
REQ-018 Internal buffer SHALL be 64 bytes with a byte count cnt in 0..64; byte 0 = oldest byte.
REQ-019 in_ready SHALL equal (cnt <= 32) and state != ERROR, computed from registered state only.
REQ-020 Input transfer when in_valid & in_ready: all 32 bytes SHALL be appended after the bytes remaining once this cycle's extraction is applied.
REQ-021 A record is complete when cnt >= 3 and cnt >= 3 + buffer byte 0.
REQ-022 Extraction fires when a record is complete and (out_valid == 0 or out_ready == 1): output registers load, out_valid = 1 next cycle, and the buffer shifts down by 3 + len bytes in the same edge.
REQ-023 When out_valid = 1 and out_ready = 0, outputs SHALL hold stable and no extraction SHALL occur.
REQ-024 When out_ready = 1 and no record is complete, out_valid SHALL drop to 0 next cycle.
REQ-025 Latency: the word completing a record is accepted at edge N; out_valid SHALL be 1 after edge N+1. Throughput SHALL be one record per cycle while records are buffered and out_ready = 1.
REQ-026 Simultaneous accept and extract in one cycle SHALL be supported: next cnt = cnt - (3+len) + 32.
REQ-027 len = 0 is legal: the record is 3 bytes, out_data = 0.
REQ-028 States: RUN, ERROR. RUN->ERROR when buffer byte 0 > MAX_LEN with cnt >= 1. The bad record SHALL NOT be emitted. err = 1 in ERROR. ERROR is exited only by reset.
REQ-029 In ERROR: in_ready = 0; any out_valid record already held SHALL still complete its handshake; no further extraction.
REQ-030 flush (RUN, highest priority over accept/extract): cnt SHALL go to 0 and the input word in the same cycle SHALL NOT be accepted (in_ready unaffected); a held output record SHALL be retained.
REQ-031 A record SHALL span at most two input words plus a carried residue; no partial record SHALL ever be emitted.

Reset
REQ-032 On reset: cnt = 0, state = RUN, out_valid = 0, out_tag = 0, out_data = 0, out_len = 0, err = 0, buffer contents don't-care.
REQ-033 Reset asserted mid-operation SHALL discard buffered bytes and any held output record in that same edge.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-035 Single record: word bytes {0x16, 0xAF, 0xAA, 22 payload bytes 0x21,0x43,...}, rest zero, out_ready = 1 -> one cycle later out_len = 0x16, out_tag = 0xAAAF, payload matches, upper 10 bytes zero, out_valid for one cycle.
REQ-036 Spanning record: two records of len 32 (35 bytes each) over three words -> both are emitted in order with exact bytes; in_ready drops when cnt > 32.
REQ-037 Backpressure: out_ready = 0 for 5 cycles with 4 complete len-0 records buffered -> first record held stable, then four consecutive out_valid cycles once out_ready = 1.
REQ-038 Illegal length: header byte 0x21 -> err = 1 next cycle, in_ready = 0, no record emitted; reset clears err and cnt.
REQ-039 Flush: 10 bytes of a partial record buffered, flush = 1 -> cnt = 0; the next word starting with a fresh header decodes correctly.
REQ-040 Reset mid-stream with out_valid = 1 -> out_valid = 0 and all outputs zero the following cycle.

Source files
------------

// File: rtl/dealigner.sv
// Record dealigner: unpacks a byte stream of {len, tag_lo, tag_hi, payload} records,
// delivered 32 bytes per word, into one record per output handshake.
module dealigner #(
  parameter int DATA_IN_WIDTH = 256,
  parameter int TAG_WIDTH     = 16,
  parameter int LEN_WIDTH     = 8,
  parameter int MAX_LEN       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_IN_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [DATA_IN_WIDTH-1:0] out_data,
  output logic [LEN_WIDTH-1:0]     out_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err
);

  localparam int InBytes = DATA_IN_WIDTH / 8;
  localparam int BufW    = 2 * DATA_IN_WIDTH;
  localparam int CntW    = $clog2(2 * InBytes + 1);

  localparam logic StRun   = 1'b0;
  localparam logic StError = 1'b1;

  logic [BufW-1:0]          buf_q, buf_d, buf_shift;
  logic [CntW-1:0]          cnt_q, cnt_d, remain;
  logic                     state_q, state_d;
  logic                     out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0]     out_tag_q, out_tag_d;
  logic [DATA_IN_WIDTH-1:0] out_data_q, out_data_d;
  logic [LEN_WIDTH-1:0]     out_len_q, out_len_d;

  logic [7:0]               hdr_len;
  logic [8:0]               need;
  logic                     bad, complete, extract, accept;
  logic [DATA_IN_WIDTH-1:0] rec_body, payload;

  assign hdr_len  = buf_q[7:0];
  assign need     = 9'd3 + {1'b0, hdr_len};
  assign in_ready = (cnt_q <= CntW'(InBytes)) && (state_q == StRun);
  assign err      = (state_q == StError);

  assign bad      = (state_q == StRun) && (cnt_q != '0) && (32'(hdr_len) > 32'(MAX_LEN));
  // need >= 3 always, so this also covers the cnt >= 3 condition
  assign complete = (state_q == StRun) && !bad && (9'(cnt_q) >= need);
  assign extract  = complete && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready && !flush;

  assign rec_body = buf_q[24 +: DATA_IN_WIDTH];

  // Bytes past len belong to the next record and must not leak into out_data
  always_comb begin
    payload = '0;
    for (int i = 0; i < InBytes; i++) begin
      if (8'(i) < hdr_len) payload[8*i +: 8] = rec_body[8*i +: 8];
    end
  end

  always_comb begin
    buf_shift = extract ? (buf_q >> {need, 3'b000}) : buf_q;
    remain    = extract ? (cnt_q - need[CntW-1:0]) : cnt_q;
    buf_d     = buf_shift;
    cnt_d     = remain;
    state_d   = state_q;
    if (accept) begin
      buf_d = buf_shift | ({{DATA_IN_WIDTH{1'b0}}, in_data} << {remain, 3'b000});
      cnt_d = remain + CntW'(InBytes);
    end
    if (bad && !flush) state_d = StError;
    if (flush && (state_q == StRun)) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    if (extract) begin
      out_valid_d = 1'b1;
      out_tag_d   = TAG_WIDTH'({buf_q[23:16], buf_q[15:8]});
      out_data_d  = payload;
      out_len_d   = LEN_WIDTH'(hdr_len);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      state_q     <= StRun;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
      out_len_q   <= '0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;

endmodule

// File: tb/tb_dealigner.sv
// Directed bench for dealigner; inputs change 1 time unit after the rising edge,
// outputs are checked at that same point.
module tb_dealigner;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [15:0]  out_tag;
  logic [255:0] out_data;
  logic [7:0]   out_len;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  int checks   = 0;
  int failures = 0;

  dealigner dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_tag  (out_tag),
    .out_data (out_data),
    .out_len  (out_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [255:0] w, w0, w1, w2, exp_d;
  logic [7:0]   s [96];

  initial begin
    in_data   = '0;
    out_ready = 1'b1;
    do_reset();

    // Reset state
    check_eq("rst_out_valid", 256'(out_valid), 256'd0);
    check_eq("rst_out_len", 256'(out_len), 256'd0);
    check_eq("rst_out_tag", 256'(out_tag), 256'd0);
    check_eq("rst_out_data", out_data, 256'd0);
    check_eq("rst_err", 256'(err), 256'd0);
    check_eq("rst_in_ready", 256'(in_ready), 256'd1);

    // Single record, len 0x16, tag 0xAAAF
    w = '0;
    w[7:0] = 8'h16; w[15:8] = 8'hAF; w[23:16] = 8'hAA;
    exp_d = '0;
    for (int k = 0; k < 22; k++) begin
      w[8*(k+3) +: 8] = 8'h21 + 8'(34 * k);
      exp_d[8*k +: 8] = 8'h21 + 8'(34 * k);
    end
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("single_latency", 256'(out_valid), 256'd0);
    step();
    check_eq("single_valid", 256'(out_valid), 256'd1);
    check_eq("single_len", 256'(out_len), 256'h16);
    check_eq("single_tag", 256'(out_tag), 256'hAAAF);
    check_eq("single_data", out_data, exp_d);
    // The 7 zero bytes after the record parse as two len-0 records plus one stray byte
    step();
    check_eq("zero_fill_len", 256'(out_len), 256'd0);
    check_eq("zero_fill_valid", 256'(out_valid), 256'd1);
    step();
    step();
    check_eq("single_drop", 256'(out_valid), 256'd0);

    // Two len-32 records spanning three words
    do_reset();
    for (int k = 0; k < 96; k++) s[k] = 8'hEE;
    s[0] = 8'h20; s[1] = 8'h34; s[2] = 8'h12;
    for (int k = 0; k < 32; k++) s[3+k] = 8'hA0 + 8'(k);
    s[35] = 8'h20; s[36] = 8'h78; s[37] = 8'h56;
    for (int k = 0; k < 32; k++) s[38+k] = 8'h40 + 8'(k);
    s[70] = 8'h20;
    for (int j = 0; j < 32; j++) begin
      w0[8*j +: 8] = s[j];
      w1[8*j +: 8] = s[32+j];
      w2[8*j +: 8] = s[64+j];
    end
    in_data = w0; in_valid = 1'b1;
    step();
    in_data = w1;
    check_eq("span_ready_32", 256'(in_ready), 256'd1);
    step();
    in_data = w2;
    check_eq("span_ready_64", 256'(in_ready), 256'd0);
    check_eq("span_no_early", 256'(out_valid), 256'd0);
    step();
    exp_d = '0;
    for (int k = 0; k < 32; k++) exp_d[8*k +: 8] = 8'hA0 + 8'(k);
    check_eq("span_a_valid", 256'(out_valid), 256'd1);
    check_eq("span_a_len", 256'(out_len), 256'h20);
    check_eq("span_a_tag", 256'(out_tag), 256'h1234);
    check_eq("span_a_data", out_data, exp_d);
    check_eq("span_ready_29", 256'(in_ready), 256'd1);
    step();
    in_valid = 1'b0;
    check_eq("span_gap", 256'(out_valid), 256'd0);
    step();
    for (int k = 0; k < 32; k++) exp_d[8*k +: 8] = 8'h40 + 8'(k);
    check_eq("span_b_valid", 256'(out_valid), 256'd1);
    check_eq("span_b_tag", 256'(out_tag), 256'h5678);
    check_eq("span_b_data", out_data, exp_d);
    step();
    check_eq("span_partial_held", 256'(out_valid), 256'd0);

    // Flush with a held output and a 10-byte partial record
    do_reset();
    out_ready = 1'b0;
    w = {32{8'h55}};
    w[7:0] = 8'h13; w[15:8] = 8'hDE; w[23:16] = 8'hC0;
    exp_d = '0;
    for (int k = 0; k < 19; k++) begin
      w[8*(k+3) +: 8] = 8'h80 + 8'(k);
      exp_d[8*k +: 8] = 8'h80 + 8'(k);
    end
    w[183:176] = 8'h1E;
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("fl_rec_len", 256'(out_len), 256'h13);
    flush = 1'b1; in_valid = 1'b1; in_data = '0;
    check_eq("fl_in_ready", 256'(in_ready), 256'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_held_valid", 256'(out_valid), 256'd1);
    check_eq("fl_held_tag", 256'(out_tag), 256'hC0DE);
    check_eq("fl_held_data", out_data, exp_d);
    out_ready = 1'b1;
    w = {32{8'h77}};
    w[7:0] = 8'h05; w[15:8] = 8'hEF; w[23:16] = 8'hBE;
    w[63:24] = 40'h05_04_03_02_01;
    w[71:64] = 8'h1F;
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("fl_junk_dropped", 256'(out_valid), 256'd0);
    step();
    check_eq("fl_new_len", 256'(out_len), 256'd5);
    check_eq("fl_new_tag", 256'(out_tag), 256'hBEEF);
    check_eq("fl_new_data", out_data, 256'h05_04_03_02_01);
    step();
    check_eq("fl_tail_wait", 256'(out_valid), 256'd0);

    // Backpressure over four len-0 records
    do_reset();
    out_ready = 1'b0;
    w = {32{8'h33}};
    for (int r = 0; r < 4; r++) begin
      w[8*(3*r) +: 8]   = 8'h00;
      w[8*(3*r+1) +: 8] = 8'(r + 1);
      w[8*(3*r+2) +: 8] = 8'(r + 1);
    end
    w[103:96] = 8'h20;
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("bp_hold_valid", 256'(out_valid), 256'd1);
      check_eq("bp_hold_tag", 256'(out_tag), 256'h0101);
    end
    out_ready = 1'b1;
    for (int r = 2; r <= 4; r++) begin
      step();
      check_eq("bp_seq_valid", 256'(out_valid), 256'd1);
      check_eq("bp_seq_tag", 256'(out_tag), 256'(16'h0101 * 16'(r)));
      check_eq("bp_seq_len", 256'(out_len), 256'd0);
    end
    step();
    check_eq("bp_done", 256'(out_valid), 256'd0);

    // Illegal length header
    do_reset();
    w = '0;
    w[7:0] = 8'h21;
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("bad_err", 256'(err), 256'd1);
    check_eq("bad_in_ready", 256'(in_ready), 256'd0);
    check_eq("bad_no_rec", 256'(out_valid), 256'd0);
    step();
    step();
    check_eq("bad_sticky", 256'(err), 256'd1);
    check_eq("bad_still_no_rec", 256'(out_valid), 256'd0);
    do_reset();
    check_eq("bad_rst_err", 256'(err), 256'd0);
    check_eq("bad_rst_ready", 256'(in_ready), 256'd1);
    w = {32{8'h11}};
    w[7:0] = 8'h01; w[15:8] = 8'h34; w[23:16] = 8'h12; w[31:24] = 8'h99; w[39:32] = 8'h20;
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("post_err_len", 256'(out_len), 256'd1);
    check_eq("post_err_tag", 256'(out_tag), 256'h1234);
    check_eq("post_err_data", out_data, 256'h99);

    // Reset while a record is held
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_valid", 256'(out_valid), 256'd0);
    check_eq("mid_rst_len", 256'(out_len), 256'd0);
    check_eq("mid_rst_tag", 256'(out_tag), 256'd0);
    check_eq("mid_rst_data", out_data, 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
